io_port_controller: RTL
=======================

# io_port_controller

Bridges the processor's 16-bit input and output ports to an external host through two small FIFOs. Host writes are queued and presented on the processor input port, and each IN instruction consumes one word. Values from OUT instructions are queued for the host. The block also drives back-pressure flags that the hazard detection unit uses to stall IN/OUT instructions. It sits at the top level beside the processor, on the stage-1 clock.

## Interface
- DEPTH, 4, entries per FIFO; power of two, 2..16
- clk  input  1  stage clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; clears both FIFOs and all registers
- host_in_data  input  16  word offered by host for the processor input port
- host_in_valid  input  1  host_in_data is valid
- host_in_ready  output  1  input FIFO can accept; equals !in_full
- cpu_in_rd  input  1  one-cycle strobe: IN instruction consumes the current word
- cpu_in_data  output  16  to processor inputPort: input FIFO head, or held last value when empty
- in_empty  output  1  input FIFO empty; HDU stalls IN while high
- cpu_out_wr  input  1  one-cycle strobe: OUT instruction in write-back
- cpu_out_data  input  16  from processor outputPort
- out_full  output  1  output FIFO full; HDU stalls OUT while high
- host_out_data  output  16  output FIFO head
- host_out_valid  output  1  output FIFO not empty
- host_out_ready  input  1  host accepts host_out_data
- last_out  output  16  most recent word accepted from cpu_out_wr
- underflow_cnt  output  8  IN reads attempted while empty (see Configuration)
- overflow_cnt  output  8  OUT writes dropped while full (see Configuration)

## Operation
- Each FIFO is a circular buffer with DEPTH×16 storage, read and write pointers of width log2(DEPTH) that wrap modulo DEPTH, and a count register of width log2(DEPTH)+1.
- Input push: host_in_valid && !in_full. Input pop: cpu_in_rd && !in_empty.
- Each pop also loads the popped word into hold_reg.
- cpu_in_data = FIFO head when !in_empty; otherwise hold_reg.
- cpu_in_rd while in_empty is an underflow:
  - no pop occurs and cpu_in_data stays at hold_reg;
  - a host push in the same cycle is still accepted;
  - the pushed word is not passed through to cpu_in_data.
- Output push: cpu_out_wr && (!out_full || host pop in the same cycle).
  - Pushing on a full FIFO is allowed only when a pop happens in the same cycle; the count then stays at DEPTH.
  - A write that cannot be pushed is dropped and counts as an overflow. last_out does not change.
- last_out loads cpu_out_data on every accepted output push.
- Output pop: host_out_valid && host_out_ready.
- Push and pop in the same cycle on a non-empty, non-full FIFO leave the count unchanged and advance both pointers.
- Input FIFO when full: host_in_ready is low, so a host push is ignored even if cpu_in_rd pops in that cycle.

## Timing
- Reset values:
  - Both counts 0, all pointers 0.
  - hold_reg 0, last_out 0, both counters 0.
  - host_in_ready=1, in_empty=1, out_full=0, host_out_valid=0, cpu_in_data=0, host_out_data=0.
- A push registers at edge N. The word appears at the head, and the flags update, after edge N; this is one cycle of latency. There is no combinational path from host_in_data to cpu_in_data.
- All flags are decoded from registered counts and are glitch-free within a cycle.
- An IN strobe at edge N: cpu_in_data shows the next word after N. The processor samples cpu_in_data in the cycle the strobe is asserted.
- Reset asserted mid-transfer: any push or pop in that cycle is discarded, and everything returns to reset values after the edge.

## Configuration
- IO_ERR_CNT_EN defined:
  - underflow_cnt and overflow_cnt are 8-bit counters that increment on each underflow or overflow event.
  - They saturate at 255 and clear on reset.
- IO_ERR_CNT_EN undefined: both outputs are tied to 0 and no counter flops are built. FIFO behaviour is identical in both builds.

## Test plan
- Reset, then host pushes 0x1111, 0x2222, 0x3333, 0x4444 (DEPTH=4) -> host_in_ready=0 after the 4th; a 5th push of 0x5555 is ignored; cpu_in_data=0x1111.
- Four cpu_in_rd strobes on a full input FIFO -> cpu_in_data steps 0x2222, 0x3333, 0x4444. After the 4th, in_empty=1 and cpu_in_data holds 0x4444.
- cpu_in_rd on an empty FIFO with a simultaneous host push of 0xABCD -> cpu_in_data stays 0x4444 for that cycle and becomes 0xABCD next cycle; underflow_cnt=1 when IO_ERR_CNT_EN.
- Five cpu_out_wr writes 0x0001..0x0005 with host_out_ready=0 -> out_full=1 after the 4th; 0x0005 is dropped; last_out=0x0004; overflow_cnt=1.
- Output FIFO full, with cpu_out_wr 0x0006 and host pop in the same cycle -> host receives 0x0001; the count stays 4; the FIFO order becomes 0x0002, 0x0003, 0x0004, 0x0006; last_out=0x0006.
- reset pulsed with both FIFOs partly full and strobes active -> all outputs return to reset values the next cycle; the counters read 0.

Source files
------------

// File: rtl/io_port_controller_if.sv
// Host/processor port bundle for io_port_controller.
// slave is the controller's view; master is the processor/host side.
interface io_port_controller_if;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic        cpu_in_rd;
  logic [15:0] cpu_in_data;
  logic        in_empty;
  logic        cpu_out_wr;
  logic [15:0] cpu_out_data;
  logic        out_full;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [15:0] last_out;
  logic [7:0]  underflow_cnt;
  logic [7:0]  overflow_cnt;

  modport slave (
    input  host_in_data, host_in_valid, cpu_in_rd, cpu_out_wr, cpu_out_data, host_out_ready,
    output host_in_ready, cpu_in_data, in_empty, out_full, host_out_data, host_out_valid,
           last_out, underflow_cnt, overflow_cnt
  );

  modport master (
    output host_in_data, host_in_valid, cpu_in_rd, cpu_out_wr, cpu_out_data, host_out_ready,
    input  host_in_ready, cpu_in_data, in_empty, out_full, host_out_data, host_out_valid,
           last_out, underflow_cnt, overflow_cnt
  );
endinterface

// File: rtl/io_port_controller.sv
// Host <-> processor I/O port bridge: input and output FIFOs plus HDU back-pressure flags.
// Define IO_ERR_CNT_EN to build the saturating underflow/overflow counters.
module io_port_controller #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  io_port_controller_if.slave  bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [15:0]     in_mem_q  [DEPTH];
  logic [PtrW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d;
  logic [15:0]     hold_q, hold_d;

  logic [15:0]     out_mem_q [DEPTH];
  logic [PtrW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]     last_q, last_d;

  logic in_full, in_empty, in_push, in_pop;
  logic out_full, out_empty, out_push, out_pop;

  always_comb begin
    in_full   = (in_cnt_q == FullCnt);
    in_empty  = (in_cnt_q == '0);
    out_full  = (out_cnt_q == FullCnt);
    out_empty = (out_cnt_q == '0);

    in_push  = bus.host_in_valid && !in_full;
    in_pop   = bus.cpu_in_rd && !in_empty;
    out_pop  = !out_empty && bus.host_out_ready;
    // A full output FIFO still takes a write when the host drains a word in the same cycle.
    out_push = bus.cpu_out_wr && (!out_full || out_pop);

    in_wptr_d  = in_wptr_q + PtrW'(in_push);
    in_rptr_d  = in_rptr_q + PtrW'(in_pop);
    in_cnt_d   = in_cnt_q + CntW'(in_push) - CntW'(in_pop);
    hold_d     = in_pop ? in_mem_q[in_rptr_q] : hold_q;

    out_wptr_d = out_wptr_q + PtrW'(out_push);
    out_rptr_d = out_rptr_q + PtrW'(out_pop);
    out_cnt_d  = out_cnt_q + CntW'(out_push) - CntW'(out_pop);
    last_d     = out_push ? bus.cpu_out_data : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_cnt_q   <= '0;
      hold_q     <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      out_cnt_q  <= '0;
      last_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        in_mem_q[i]  <= '0;
        out_mem_q[i] <= '0;
      end
    end else begin
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_cnt_q   <= in_cnt_d;
      hold_q     <= hold_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
      last_q     <= last_d;
      if (in_push)  in_mem_q[in_wptr_q]   <= bus.host_in_data;
      if (out_push) out_mem_q[out_wptr_q] <= bus.cpu_out_data;
    end
  end

  assign bus.host_in_ready  = !in_full;
  assign bus.in_empty       = in_empty;
  assign bus.cpu_in_data    = in_empty ? hold_q : in_mem_q[in_rptr_q];
  assign bus.out_full       = out_full;
  assign bus.host_out_valid = !out_empty;
  assign bus.host_out_data  = out_mem_q[out_rptr_q];
  assign bus.last_out       = last_q;

`ifdef IO_ERR_CNT_EN
  logic [7:0] under_q, under_d, over_q, over_d;

  always_comb begin
    under_d = under_q;
    over_d  = over_q;
    if (bus.cpu_in_rd && in_empty && (under_q != 8'hFF)) under_d = under_q + 8'd1;
    if (bus.cpu_out_wr && !out_push && (over_q != 8'hFF)) over_d = over_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      under_q <= '0;
      over_q  <= '0;
    end else begin
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign bus.underflow_cnt = under_q;
  assign bus.overflow_cnt  = over_q;
`else
  assign bus.underflow_cnt = '0;
  assign bus.overflow_cnt  = '0;
`endif
endmodule
